// File: rtl/pattern_gen_stream.sv
// pattern_gen_stream
//   Video test-pattern source on an AXI4-Stream style output. It produces
//   X_SIZE x Y_SIZE frames, one beat per pixel, from one of four patterns:
//   gradient, 8 colour bars, checkerboard, or solid colour.
//   Pattern controls are captured into shadow registers at each frame
//   boundary, so changing them mid-frame has no visible effect.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   enable               run request; checked in IDLE and at each frame end
//   mode                 0 gradient, 1 colour bars, 2 checkerboard, 3 solid
//   frame_offset         gradient offset
//   solid_rgb            solid colour {r,g,b}
//   out_stream_t*        pixel stream; tuser = start of frame, tlast = end of line
//   frame_count          frames completed since reset (wraps at 16 bits)
//   busy                 high while in RUN
//
// Configuration
//   PATGEN_AUTO_ANIM_EN  when defined, frame_count is added to the gradient
//                        offset at every frame latch so the gradient scrolls.
module pattern_gen_stream #(
   parameter int X_SIZE     = 640,
   parameter int Y_SIZE     = 480,
   parameter int COLOUR_W   = 8,
   parameter int CHECK_LOG2 = 5
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [COLOUR_W-1:0]   frame_offset,
   input  logic [3*COLOUR_W-1:0] solid_rgb,
   output logic [3*COLOUR_W-1:0] out_stream_tdata,
   output logic                  out_stream_tvalid,
   input  logic                  out_stream_tready,
   output logic                  out_stream_tuser,
   output logic                  out_stream_tlast,
   output logic [15:0]           frame_count,
   output logic                  busy
);

   localparam int XW    = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int YW    = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
   localparam int BAR_W = X_SIZE / 8;
   localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [XW-1:0] X_LAST   = XW'(X_SIZE - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(Y_SIZE - 1);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]            state;
   logic                  primed;     // one-cycle warm-up after leaving IDLE
   logic [1:0]            sh_mode;
   logic [COLOUR_W-1:0]   sh_off;     // effective gradient offset for this frame
   logic [3*COLOUR_W-1:0] sh_solid;
   logic [XW-1:0]         x;          // coordinates of the next pixel to load
   logic [YW-1:0]         y;
   logic [2:0]            bar_idx;
   logic [BW-1:0]         bar_cnt;
   logic                  out_eof;    // output register holds pixel (X-1,Y-1)

   logic                  xfer, eof_xfer, relatch, load;
   logic [15:0]           fcnt_nxt;
   logic [COLOUR_W-1:0]   off_idle, off_relatch;
   logic [1:0]            g_mode;
   logic [COLOUR_W-1:0]   g_off;
   logic [3*COLOUR_W-1:0] g_solid, pix;
   logic [COLOUR_W-1:0]   xc, yc, xyc;
   logic [31:0]           xe, ye;

   assign xfer     = out_stream_tvalid & out_stream_tready;
   assign eof_xfer = xfer & out_eof;
   assign relatch  = eof_xfer & enable;
   assign fcnt_nxt = frame_count + 16'd1;
   assign busy     = (state == ST_RUN);

   // The output register refills when empty or draining, except at a frame
   // end where the source is about to stop.
   assign load = (state == ST_RUN) & primed & (~out_stream_tvalid | xfer) &
                 ~(eof_xfer & ~enable);

`ifdef PATGEN_AUTO_ANIM_EN
   logic [COLOUR_W+15:0] fcnt_ext, fcnt_nxt_ext;
   assign fcnt_ext     = {{COLOUR_W{1'b0}}, frame_count};
   assign fcnt_nxt_ext = {{COLOUR_W{1'b0}}, fcnt_nxt};
   assign off_idle     = frame_offset + fcnt_ext[COLOUR_W-1:0];
   // At a frame-end relatch frame_count is incrementing on the same edge,
   // so the new frame uses the post-increment value.
   assign off_relatch  = frame_offset + fcnt_nxt_ext[COLOUR_W-1:0];
`else
   assign off_idle     = frame_offset;
   assign off_relatch  = frame_offset;
`endif

   // Pixel (0,0) of a back-to-back frame is generated on the same edge that
   // latches the shadows, so it must see the incoming controls directly.
   assign g_mode  = relatch ? mode        : sh_mode;
   assign g_off   = relatch ? off_relatch : sh_off;
   assign g_solid = relatch ? solid_rgb   : sh_solid;

   always_comb begin
      pix = '0;
      xe  = 32'(x);
      ye  = 32'(y);
      xc  = COLOUR_W'(x);
      yc  = COLOUR_W'(y);
      xyc = xc + yc;
      case (g_mode)
         2'd0: pix = {xc + g_off, yc + g_off, xyc + g_off};
         2'd1: pix = {{COLOUR_W{~bar_idx[1]}}, {COLOUR_W{~bar_idx[2]}},
                      {COLOUR_W{~bar_idx[0]}}};
         2'd2: pix = {(3*COLOUR_W){xe[CHECK_LOG2] ^ ye[CHECK_LOG2]}};
         default: pix = g_solid;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state             <= ST_IDLE;
         primed            <= 1'b0;
         sh_mode           <= '0;
         sh_off            <= '0;
         sh_solid          <= '0;
         x                 <= '0;
         y                 <= '0;
         bar_idx           <= '0;
         bar_cnt           <= '0;
         out_eof           <= 1'b0;
         out_stream_tdata  <= '0;
         out_stream_tvalid <= 1'b0;
         out_stream_tuser  <= 1'b0;
         out_stream_tlast  <= 1'b0;
         frame_count       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  sh_mode  <= mode;
                  sh_off   <= off_idle;
                  sh_solid <= solid_rgb;
                  x        <= '0;
                  y        <= '0;
                  bar_idx  <= '0;
                  bar_cnt  <= '0;
                  primed   <= 1'b0;
                  state    <= ST_RUN;
               end
            end
            default: begin
               primed <= 1'b1;
               if (eof_xfer) begin
                  frame_count <= fcnt_nxt;
                  if (enable) begin
                     sh_mode  <= mode;
                     sh_off   <= off_relatch;
                     sh_solid <= solid_rgb;
                  end else begin
                     state             <= ST_IDLE;
                     primed            <= 1'b0;
                     out_stream_tvalid <= 1'b0;
                  end
               end
               if (load) begin
                  out_stream_tdata  <= pix;
                  out_stream_tvalid <= 1'b1;
                  out_stream_tuser  <= (x == '0) && (y == '0);
                  out_stream_tlast  <= (x == X_LAST);
                  out_eof           <= (x == X_LAST) && (y == Y_LAST);
                  if (x == X_LAST) begin
                     x       <= '0;
                     bar_idx <= '0;
                     bar_cnt <= '0;
                     y       <= (y == Y_LAST) ? '0 : y + 1'b1;
                  end else begin
                     x <= x + 1'b1;
                     if (bar_cnt == BAR_LAST) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 3'd1;
                     end else begin
                        bar_cnt <= bar_cnt + 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_gen_stream.sv
// Directed bench for pattern_gen_stream at X=16, Y=4, COLOUR_W=8, CHECK_LOG2=2.
module tb_pattern_gen_stream;
   localparam int XS = 16;
   localparam int YS = 4;
   localparam int CW = 8;
   localparam int CL = 2;

`ifdef PATGEN_AUTO_ANIM_EN
   localparam bit ANIM = 1'b1;
`else
   localparam bit ANIM = 1'b0;
`endif

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic            enable = 1'b0;
   logic [1:0]      mode = 2'd0;
   logic [CW-1:0]   frame_offset = '0;
   logic [3*CW-1:0] solid_rgb = '0;
   logic [3*CW-1:0] tdata;
   logic            tvalid, tuser, tlast, busy;
   logic            tready = 1'b0;
   logic [15:0]     frame_count;

   pattern_gen_stream #(.X_SIZE(XS), .Y_SIZE(YS), .COLOUR_W(CW), .CHECK_LOG2(CL)) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode),
      .frame_offset(frame_offset), .solid_rgb(solid_rgb),
      .out_stream_tdata(tdata), .out_stream_tvalid(tvalid),
      .out_stream_tready(tready), .out_stream_tuser(tuser),
      .out_stream_tlast(tlast), .frame_count(frame_count), .busy(busy)
   );

   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_fail = 0;

   logic [23:0] bd[$];
   bit          bu[$];
   bit          bl[$];
   int          bc[$];
   int          first_cyc;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic start(input bit hold);
      @(negedge aclk);
      enable = 1'b1;
      @(negedge aclk);
      enable = hold;
   endtask

   // Collect n transferred beats, sampling at negedge. Optionally toggles
   // tready 1,0,0,1, changes controls at beat chg_at, drops enable at dis_at.
   task automatic grab(input int n, input bit toggle, input int chg_at, input int dis_at);
      int          cyc;
      logic        pv, pr;
      logic [25:0] pd;
      bd.delete(); bu.delete(); bl.delete(); bc.delete();
      first_cyc = -1;
      cyc = 0; pv = 1'b0; pr = 1'b0; pd = '0;
      while (bd.size() < n && cyc < 2000) begin
         @(negedge aclk);
         if (pv && !pr) begin
            chk("stall_valid", 64'(tvalid), 64'd1);
            chk("stall_hold", 64'({tdata, tuser, tlast}), 64'(pd));
         end
         tready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (tvalid && first_cyc < 0) first_cyc = cyc;
         if (tvalid && tready) begin
            if (bd.size() == chg_at) begin
               mode = 2'd0;
               frame_offset = 8'h20;
            end
            if (bd.size() == dis_at) enable = 1'b0;
            bd.push_back(tdata);
            bu.push_back(tuser);
            bl.push_back(tlast);
            bc.push_back(cyc);
         end
         pv = tvalid; pr = tready; pd = {tdata, tuser, tlast};
         cyc++;
      end
      if (bd.size() < n) chk("grab_timeout", 64'(bd.size()), 64'(n));
   endtask

   task automatic wait_idle();
      int c = 0;
      while (busy && c < 300) begin
         @(negedge aclk);
         c++;
      end
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_tvalid", 64'(tvalid), 64'd0);
   endtask

   initial begin
      int ucnt, lcnt, bad;
      logic [7:0] off2;

      // Reset state
      #1;
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_fc", 64'(frame_count), 64'd0);
      chk("rst_tdata", 64'(tdata), 64'd0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;

      // Gradient, one-cycle enable pulse
      mode = 2'd0; frame_offset = 8'h10; tready = 1'b1;
      @(negedge aclk);
      enable = 1'b1;
      @(negedge aclk);
      enable = 1'b0;
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_tvalid_early", 64'(tvalid), 64'd0);
      grab(64, 1'b0, -1, -1);
      chk("t1_first_lat", 64'(first_cyc), 64'd1);
      chk("t1_beats", 64'(bd.size()), 64'd64);
      chk("t1_d0", 64'(bd[0]), 64'h101010);
      chk("t1_u0", 64'(bu[0]), 64'd1);
      chk("t1_d15", 64'(bd[15]), 64'h1F101F);
      chk("t1_l15", 64'(bl[15]), 64'd1);
      chk("t1_d63", 64'(bd[63]), 64'h1F1322);
      ucnt = 0; lcnt = 0;
      foreach (bu[i]) begin
         ucnt += int'(bu[i]);
         lcnt += int'(bl[i]);
      end
      chk("t1_tuser_cnt", 64'(ucnt), 64'd1);
      chk("t1_tlast_cnt", 64'(lcnt), 64'd4);
      wait_idle();
      chk("t1_fc", 64'(frame_count), 64'd1);

      // Colour bars
      mode = 2'd1;
      start(1'b0);
      grab(64, 1'b0, -1, -1);
      chk("t2_x0", 64'(bd[0]), 64'hFFFFFF);
      chk("t2_x1", 64'(bd[1]), 64'hFFFFFF);
      chk("t2_x2", 64'(bd[2]), 64'hFFFF00);
      chk("t2_x3", 64'(bd[3]), 64'hFFFF00);
      chk("t2_x4", 64'(bd[4]), 64'h00FFFF);
      chk("t2_x14", 64'(bd[14]), 64'h000000);
      chk("t2_x15", 64'(bd[15]), 64'h000000);
      chk("t2_line1_x0", 64'(bd[16]), 64'hFFFFFF);
      wait_idle();

      // Checkerboard with tready 1,0,0,1
      mode = 2'd2;
      start(1'b0);
      grab(64, 1'b1, -1, -1);
      chk("t3_beats", 64'(bd.size()), 64'd64);
      chk("t3_x0y0", 64'(bd[0]), 64'h000000);
      chk("t3_x4y0", 64'(bd[4]), 64'hFFFFFF);
      chk("t3_x8y0", 64'(bd[8]), 64'h000000);
      chk("t3_x12y0", 64'(bd[12]), 64'hFFFFFF);
      chk("t3_x4y1", 64'(bd[20]), 64'hFFFFFF);
      chk("t3_u0", 64'(bu[0]), 64'd1);
      wait_idle();
      tready = 1'b1;
      chk("t3_fc", 64'(frame_count), 64'd3);

      // Solid, enable held, controls change mid-frame
      mode = 2'd3; solid_rgb = 24'h123456; frame_offset = 8'h00;
      start(1'b1);
      grab(128, 1'b0, 10, 100);
      bad = 0;
      for (int i = 0; i < 64; i++) if (bd[i] != 24'h123456) bad++;
      chk("t4_solid_bad", 64'(bad), 64'd0);
      off2 = ANIM ? 8'h24 : 8'h20;
      chk("t4_f2_d0", 64'(bd[64]), 64'({off2, off2, off2}));
      chk("t4_f2_u0", 64'(bu[64]), 64'd1);
      chk("t4_no_bubble", 64'(bc[64] - bc[63]), 64'd1);
      chk("t4_f2_d1", 64'(bd[65]), 64'({off2 + 8'd1, off2, off2 + 8'd1}));
      chk("t4_f2_last", 64'(bd[127]), 64'({off2 + 8'd15, off2 + 8'd3, off2 + 8'd18}));
      wait_idle();
      chk("t4_fc", 64'(frame_count), 64'd5);

      // Reset mid-frame
      mode = 2'd0; frame_offset = 8'h10;
      start(1'b0);
      grab(20, 1'b0, -1, -1);
      aresetn = 1'b0;
      #1;
      chk("t5_rst_tvalid", 64'(tvalid), 64'd0);
      chk("t5_rst_fc", 64'(frame_count), 64'd0);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_tdata", 64'(tdata), 64'd0);
      chk("t5_rst_tuser", 64'(tuser), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      start(1'b0);
      grab(64, 1'b0, -1, -1);
      chk("t5_first_lat", 64'(first_cyc), 64'd1);
      chk("t5_d0", 64'(bd[0]), 64'h101010);
      chk("t5_u0", 64'(bu[0]), 64'd1);
      wait_idle();
      chk("t5_fc", 64'(frame_count), 64'd1);

      // Gradient offset 0, two frames from a clean reset
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      mode = 2'd0; frame_offset = 8'h00;
      start(1'b1);
      grab(128, 1'b0, -1, 70);
      chk("t6_f1_d0", 64'(bd[0]), 64'h000000);
      chk("t6_f2_d0", 64'(bd[64]), ANIM ? 64'h010101 : 64'h000000);
      chk("t6_f2_u0", 64'(bu[64]), 64'd1);
      wait_idle();
      chk("t6_fc", 64'(frame_count), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_gen_stream.md
PATTERN_GEN_STREAM -- requirements
Module: pattern_gen_stream

Interface
REQ-001 Parameter X_SIZE, default 640, active pixels per line (multiple of 8, >=8).
REQ-002 Parameter Y_SIZE, default 480, lines per frame (>=1).
REQ-003 Parameter COLOUR_W, default 8, bits per colour channel (>=4).
REQ-004 Parameter CHECK_LOG2, default 5, log2 of checkerboard square size in pixels (< COLOUR_W... clog2(X_SIZE)).
REQ-005 aclk  input  1  single clock; all state on rising edge.
REQ-006 aresetn  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  run request; sampled each cycle.
REQ-008 mode  input  2  pattern select: 0 gradient, 1 colour bars, 2 checkerboard, 3 solid.
REQ-009 frame_offset  input  COLOUR_W  gradient offset.
REQ-010 solid_rgb  input  3*COLOUR_W  solid colour, {r,g,b}.
REQ-011 out_stream_tdata  output  3*COLOUR_W  pixel {r,g,b}.
REQ-012 out_stream_tvalid  output  1  beat valid.
REQ-013 out_stream_tready  input  1  sink ready.
REQ-014 out_stream_tuser  output  1  start of frame, high on pixel (0,0) only.
REQ-015 out_stream_tlast  output  1  end of line, high on x = X_SIZE-1.
REQ-016 frame_count  output  16  completed frames since reset.
REQ-017 busy  output  1  high while state is RUN.

Function
REQ-018 Two states SHALL exist: IDLE (out_stream_tvalid=0) and RUN.
REQ-019 IDLE with enable=1 SHALL latch mode, frame_offset and solid_rgb into shadow registers, clear x and y, and move to RUN.
REQ-020 The first beat, pixel (0,0), SHALL be presented with tvalid=1 exactly two rising edges after the edge that sampled enable=1 in IDLE.
REQ-021 A beat SHALL transfer only when tvalid and tready are both 1; x SHALL advance only on a transfer, wrapping X_SIZE-1 -> 0 with y incrementing, and y wrapping Y_SIZE-1 -> 0.
REQ-022 While tvalid=1 and tready=0, tdata, tuser and tlast SHALL hold stable, and tvalid SHALL not drop.
REQ-023 The output register SHALL reload when tvalid=0 or a transfer occurs, giving one beat per cycle under continuous tready=1.
REQ-024 On transfer of pixel (X_SIZE-1, Y_SIZE-1), frame_count SHALL increment, wrapping 0xFFFF -> 0.
REQ-025 At that same edge, enable=1 SHALL re-latch the shadow registers and continue with (0,0) with no bubble.
REQ-026 At that same edge, enable=0 SHALL return to IDLE, and tvalid SHALL be 0 on the next cycle.
REQ-027 Deasserting enable mid-frame SHALL not truncate the frame.
REQ-028 Input changes on mode, frame_offset or solid_rgb mid-frame SHALL have no effect until the next frame boundary.
REQ-029 Gradient: r = x+off, g = y+off, b = x+y+off, where off is the effective offset; all sums are truncated to the low COLOUR_W bits.
REQ-030 Colour bars: 8 bars, each X_SIZE/8 wide, bar index i SHALL come from a counter (no divider), and r = ~i[1], g = ~i[2], b = ~i[0] expanded to all-ones/zero, giving white, yellow, cyan, green, magenta, red, blue, black.
REQ-031 Checkerboard: x[CHECK_LOG2]^y[CHECK_LOG2] = 1 SHALL give all-ones, otherwise zero.
REQ-032 Solid: tdata SHALL equal the shadow solid_rgb.

Reset
REQ-033 aresetn=0 SHALL immediately force state=IDLE, tvalid=0, tdata=0, tuser=0, tlast=0, busy=0, frame_count=0, x=y=0 and shadows=0, including mid-frame.
REQ-034 After aresetn release, the first beat SHALL follow REQ-020 rules.

Configuration
REQ-035 Macro PATGEN_AUTO_ANIM_EN defined: effective offset = shadow frame_offset + frame_count[COLOUR_W-1:0], sampled at frame latch, so the gradient scrolls each frame.
REQ-036 Macro PATGEN_AUTO_ANIM_EN undefined: effective offset = shadow frame_offset only.

Verification (X_SIZE=16, Y_SIZE=4, COLOUR_W=8, CHECK_LOG2=2)
REQ-037 Mode 0, offset 0x10, enable pulse 1 cycle, tready=1 -> 64 beats; first tdata 0x101010 with tuser=1; beat 15 tdata 0x1F101F with tlast=1; frame_count=1; return to IDLE.
REQ-038 Mode 1, tready=1 -> beats at x=0,1 give 0xFFFFFF; x=2,3 give 0xFFFF00; x=14,15 give 0x000000.
REQ-039 Mode 2 with tready toggling 1,0,0,1 repeating -> tdata/tuser/tlast stable while stalled; 64 transfers exactly; x=4,y=0 gives 0xFFFFFF.
REQ-040 Mode 3 solid 0x123456, enable held high, mode changed to 0 at beat 10 -> frame 1 all 0x123456; frame 2 gradient starts with no idle cycle between the two frames.
REQ-041 aresetn low at beat 20 -> tvalid=0 and frame_count=0 with no clock edge; enable=1 after release -> (0,0) with tuser=1 two edges later.
REQ-042 PATGEN_AUTO_ANIM_EN defined, mode 0, offset 0, enable held -> frame 2 first tdata 0x010101.
